rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters; legal range 2..16.
REQ-002 SHALL have parameter MAX_HOLD, default 8: maximum consecutive grant cycles per owner while others wait; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, NUM_REQ bits: request vector; bit i is requester i; level-sensitive.
REQ-006 SHALL have port gnt, output, NUM_REQ bits: registered one-hot grant, or all-zero when idle.
REQ-007 SHALL have port gnt_id, output, $clog2(NUM_REQ) bits: index of current owner; 0 when idle.
REQ-008 SHALL have port gnt_valid, output, 1 bit: high iff gnt is non-zero.
REQ-009 SHALL have port hold_cnt, output, 8 bits: cycles the current owner has held the grant, counting the grant cycle as 1.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner k).
REQ-011 SHALL keep a rotating priority pointer ptr in 0..NUM_REQ-1; the search order starts at ptr and ascends modulo NUM_REQ.
REQ-012 SHALL select the winner as the first set bit of the search vector in that order; on every new grant, ptr <= (winner+1) mod NUM_REQ.
REQ-013 SHALL register all outputs: a request sampled at edge n produces gnt at edge n; it is visible during cycle n+1 (1-cycle latency).
REQ-014 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0 and hold_cnt=0.
REQ-015 In IDLE with req!=0, the block SHALL grant the winner, go to GRANT, and set hold_cnt=1.
REQ-016 In GRANT, if req[k]=0, the block SHALL move the grant to the winner of the remaining requests with no idle bubble; if no request remains, it SHALL go to IDLE.
REQ-017 In GRANT, if req[k]=1 and hold_cnt<MAX_HOLD, the block SHALL keep owner k and increment hold_cnt.
REQ-018 In GRANT, if req[k]=1, hold_cnt==MAX_HOLD, and any other req bit is set, the block SHALL force rotation to the winner among the other requesters and reset hold_cnt=1.
REQ-019 In GRANT, if req[k]=1 and no other req bit is set, the block SHALL keep owner k with hold_cnt saturating at MAX_HOLD.
REQ-020 The winner search in REQ-016 and REQ-018 SHALL exclude k and use the ptr already advanced past k, so every requester is served within (NUM_REQ-1)*MAX_HOLD+1 cycles of asserting (starvation-free).
REQ-021 gnt SHALL never have more than one bit set, and SHALL never be set for a requester whose req was 0 at the sampling edge.
REQ-022 Simultaneous owner release and new requests SHALL resolve in the same edge per REQ-016; requests arriving and dropping between edges are not seen.

Reset
REQ-023 While rst=0, the block SHALL asynchronously force gnt=0, gnt_id=0, gnt_valid=0, hold_cnt=0, ptr=0, and state=IDLE, independent of clk.
REQ-024 Reset deassertion SHALL take effect at the first rising edge after rst goes high; req sampled at that edge SHALL be arbitrated normally.
REQ-025 Reset asserted mid-grant SHALL drop the grant immediately, with no completion of the hold.

Verification (NUM_REQ=4, MAX_HOLD=3)
REQ-026 Reset: drive rst=0 mid-cycle with req=1111 -> gnt=0000, gnt_valid=0, hold_cnt=0 immediately, before the next edge.
REQ-027 Single request: after reset, req=0001 -> gnt=0001 at the next edge, gnt_id=0, hold_cnt 1,2,3,3,... while held.
REQ-028 Full load: hold req=1111 -> gnt sequence 0001 x3, 0010 x3, 0100 x3, 1000 x3, then 0001 again.
REQ-029 Early release: owner 1 (gnt=0010, so ptr=2); change req to 0101 -> gnt=0100 at the next edge, with no idle cycle.
REQ-030 Sole requester: only req[0]=1 for 10 cycles -> gnt stays 0001 and hold_cnt stays at 3; when req[2] is raised -> gnt=0100 at the next edge.
REQ-031 Release to idle: req drops to 0000 -> gnt=0000, gnt_valid=0 at the next edge; the checker asserts one-hot/zero gnt and REQ-020 latency on every cycle.

Source files
------------

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Function : Round-robin arbiter with bounded hold time and registered grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       gnt_valid,
  output logic [7:0]                 hold_cnt
);

  localparam int                 IW          = $clog2(NUM_REQ);
  localparam logic [7:0]         C_MAX_HOLD  = 8'(MAX_HOLD);
  localparam logic [NUM_REQ-1:0] C_ONE       = NUM_REQ'(1);
  localparam logic [IW-1:0]      C_LAST      = IW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       w_ptr_nxt;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       w_owner_nxt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  w_gnt_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic [7:0]          r_hold;
  logic [7:0]          w_hold_nxt;

  logic [NUM_REQ-1:0]  w_kmask;
  logic [NUM_REQ-1:0]  w_others;
  logic [IW-1:0]       w_pick_all;
  logic [IW-1:0]       w_pick_oth;
  logic [IW-1:0]       w_win;
  logic                w_take;

  // First set bit of v, searching upward from p and wrapping at NUM_REQ.
  function automatic logic [IW-1:0] f_pick(input logic [NUM_REQ-1:0] v,
                                           input logic [IW-1:0]      p);
    logic [IW-1:0] res;
    logic [IW:0]   idx;
    logic          found;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, p} + (IW+1)'(i);
      if (idx >= (IW+1)'(NUM_REQ)) begin
        idx = idx - (IW+1)'(NUM_REQ);
      end
      if (!found && v[idx[IW-1:0]]) begin
        res   = idx[IW-1:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] w);
    return (w == C_LAST) ? '0 : w + IW'(1);
  endfunction

  assign w_kmask    = C_ONE << r_owner;
  assign w_others   = req & ~w_kmask;
  assign w_pick_all = f_pick(req, r_ptr);
  // r_ptr already points past the owner, so the search naturally starts after k.
  assign w_pick_oth = f_pick(w_others, r_ptr);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_gnt_nxt   = r_gnt;
    w_valid_nxt = r_valid;
    w_hold_nxt  = r_hold;
    w_take      = 1'b0;
    w_win       = '0;

    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_take = 1'b1;
          w_win  = w_pick_all;
        end
      end
      S_GRANT: begin
        if (!req[r_owner]) begin
          if (|w_others) begin
            w_take = 1'b1;
            w_win  = w_pick_oth;
          end else begin
            w_state_nxt = S_IDLE;
            w_owner_nxt = '0;
            w_gnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_hold_nxt  = '0;
          end
        end else if (r_hold < C_MAX_HOLD) begin
          w_hold_nxt = r_hold + 8'd1;
        end else if (|w_others) begin
          w_take = 1'b1;
          w_win  = w_pick_oth;
        end
        // Sole requester at the limit: hold_cnt saturates, owner kept.
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = '0;
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_hold_nxt  = '0;
      end
    endcase

    if (w_take) begin
      w_state_nxt = S_GRANT;
      w_owner_nxt = w_win;
      w_gnt_nxt   = C_ONE << w_win;
      w_valid_nxt = 1'b1;
      w_hold_nxt  = 8'd1;
      w_ptr_nxt   = f_inc(w_win);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_gnt   <= w_gnt_nxt;
      r_valid <= w_valid_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_owner;
  assign gnt_valid = r_valid;
  assign hold_cnt  = r_hold;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// ============================================================================
// Module   : tb_rr_arbiter
// Function : Scoreboard bench for rr_arbiter (NUM_REQ=4, MAX_HOLD=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter;

  localparam int N     = 4;
  localparam int MAXH  = 3;
  localparam int BOUND = (N - 1) * MAXH;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         gnt_valid;
  logic [7:0]   hold_cnt;

  rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAXH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .hold_cnt  (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int gnt;
    int id;
    int valid;
    int hold;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int   m_busy, m_owner, m_ptr, m_hold;
  int   wcnt[N];

  task automatic t_check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int f_pick(input int v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  task automatic m_grant(input int w);
    m_busy  = 1;
    m_owner = w;
    m_ptr   = (w + 1) % N;
    m_hold  = 1;
  endtask

  task automatic m_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
    for (int i = 0; i < N; i++) wcnt[i] = 0;
  endtask

  task automatic m_step(input int r);
    int others;
    if (m_busy == 0) begin
      if (r != 0) m_grant(f_pick(r, m_ptr));
    end else begin
      others = r & ~(1 << m_owner);
      if (r[m_owner] == 1'b0) begin
        if (others != 0) m_grant(f_pick(others, m_ptr));
        else begin m_busy = 0; m_owner = 0; m_hold = 0; end
      end else if (m_hold < MAXH) begin
        m_hold++;
      end else if (others != 0) begin
        m_grant(f_pick(others, m_ptr));
      end
    end
  endtask

  // Drive one request vector mid-cycle, predict, then compare after the edge.
  task automatic t_cycle(input logic [N-1:0] r);
    exp_t e;
    int   worst;
    @(negedge clk);
    req = r;
    m_step(int'(r));
    e.gnt   = m_busy ? (1 << m_owner) : 0;
    e.id    = m_owner;
    e.valid = m_busy;
    e.hold  = m_hold;
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    t_check("gnt",       int'(gnt),       e.gnt);
    t_check("gnt_id",    int'(gnt_id),    e.id);
    t_check("gnt_valid", int'(gnt_valid), e.valid);
    t_check("hold_cnt",  int'(hold_cnt),  e.hold);
    t_check("onehot",    int'($countones(gnt) <= 1), 1);
    t_check("gnt_in_req", int'(gnt & ~req), 0);
    worst = 0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !gnt[i]) wcnt[i]++;
      else wcnt[i] = 0;
      if (wcnt[i] > worst) worst = wcnt[i];
    end
    t_check("starve", int'(worst <= BOUND), 1);
  endtask

  // Assert reset mid-cycle, verify outputs clear before any edge, release.
  task automatic t_reset(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    #2;
    rst = 1'b0;
    #1;
    t_check("rst_gnt",   int'(gnt),       0);
    t_check("rst_valid", int'(gnt_valid), 0);
    t_check("rst_hold",  int'(hold_cnt),  0);
    t_check("rst_id",    int'(gnt_id),    0);
    m_reset();
    @(negedge clk);
    req = '0;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single requester: hold count climbs then saturates.
    for (int c = 0; c < 5; c++) t_cycle(4'b0001);
    t_check("single_hold_sat", int'(hold_cnt), MAXH);
    t_cycle(4'b0000);

    // Full load from reset: each owner served MAXH cycles in order.
    t_reset(4'b1111);
    for (int c = 0; c < 4 * MAXH + 1; c++) begin
      t_cycle(4'b1111);
      t_check("full_load_seq", int'(gnt), 1 << ((c / MAXH) % N));
    end

    // Early release of owner 1 hands over without a bubble.
    t_reset(4'b0000);
    t_cycle(4'b0010);
    t_cycle(4'b0101);
    t_check("early_release", int'(gnt), 4'b0100);

    // Sole requester holds indefinitely, yields as soon as another appears.
    for (int c = 0; c < 10; c++) t_cycle(4'b0001);
    t_check("sole_gnt",  int'(gnt),      4'b0001);
    t_check("sole_hold", int'(hold_cnt), MAXH);
    t_cycle(4'b0101);
    t_check("sole_yield", int'(gnt), 4'b0100);

    t_cycle(4'b0000);
    t_check("to_idle", int'(gnt_valid), 0);

    // Random traffic.
    for (int c = 0; c < 80; c++) t_cycle(4'($urandom_range(0, 15)));

    // Reset while a grant is held.
    for (int c = 0; c < 2; c++) t_cycle(4'b1111);
    t_reset(4'b1111);
    for (int c = 0; c < 4; c++) t_cycle(4'b1010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
